fft_stream_ctrl: RTL and testbench

Parametrised stream controller between the sample front-end and the vendor FFT core. It sends the core's config word after reset and again at frame boundaries whenever the transform direction or scaling schedule changes. It generates the core's input `tlast` from a frame counter and flags malformed source frames. It buffers core output through a 2-entry skid buffer with real downstream back-pressure and a bin index.

---
 rtl/fft_ctrl_pkg.sv | 12 +
 rtl/fft_skid_fifo.sv | 70 +++++++
 rtl/fft_stream_ctrl.sv | 133 +++++++++++++
 tb/tb_fft_stream_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and config-word field offsets for the FFT stream controller.
package fft_ctrl_pkg;

    typedef enum logic {
        CFG_SEND = 1'b0,
        RUN      = 1'b1
    } cfg_state_t;

    localparam int CFG_MODE_BIT  = 0;
    localparam int CFG_SCALE_LSB = 1;

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry skid FIFO. The ready it advertises is registered, yet it can never
// overflow: the flop is loaded from the next-cycle occupancy, so it drops in
// the same cycle the second entry lands.
module fft_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         rdy_q, rdy_d;
    logic         push, pop;

    // Occupancy update; entry 0 is always the head.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        push  = in_valid && rdy_q;
        pop   = (cnt_q != 2'd0) && out_ready;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = in_data;
                else               e1_d = in_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = in_data;
                end else begin
                    e0_d = in_data;
                end
            end
            default: ;
        endcase
        rdy_d = (cnt_d < 2'd2);
    end

    // Storage, count and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = e0_q;

endmodule

// File: rtl/fft_stream_ctrl.sv
// Stream controller in front of the FFT core: config sequencing, input framing
// from a local beat counter, and a skid-buffered output with bin index.
module fft_stream_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NFFT_LOG2 = 10,
    parameter int SCALE_W   = 8,
    parameter int CFG_W     = 16
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in_re,
    input  logic [DATA_W-1:0]     data_in_im,
    input  logic                  data_in_en,
    input  logic                  data_in_last,
    output logic                  data_in_ready,
    input  logic                  fft_mode,
    input  logic [SCALE_W-1:0]    scale_sch,
    output logic                  cfg_tvalid,
    input  logic                  cfg_tready,
    output logic [CFG_W-1:0]      cfg_tdata,
    output logic                  core_s_tvalid,
    input  logic                  core_s_tready,
    output logic [2*DATA_W-1:0]   core_s_tdata,
    output logic                  core_s_tlast,
    input  logic                  core_m_tvalid,
    output logic                  core_m_tready,
    input  logic [2*DATA_W-1:0]   core_m_tdata,
    input  logic                  core_m_tlast,
    output logic [DATA_W-1:0]     data_out_re,
    output logic [DATA_W-1:0]     data_out_im,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last,
    output logic [NFFT_LOG2-1:0]  data_out_idx,
    output logic                  in_err,
    output logic                  out_err,
    output logic                  cfg_busy
);
    localparam logic [NFFT_LOG2-1:0] CNT_LAST = '1;
    localparam logic [NFFT_LOG2-1:0] CNT_ONE  = NFFT_LOG2'(1);
    localparam int                   FIFO_W   = 2*DATA_W + 1;

    cfg_state_t           state_q, state_d;
    logic                 mode_l_q, mode_l_d;
    logic [SCALE_W-1:0]   scale_l_q, scale_l_d;
    logic                 reconf_pend_q, reconf_pend_d;
    logic [NFFT_LOG2-1:0] in_cnt_q, in_cnt_d;
    logic [NFFT_LOG2-1:0] out_idx_q, out_idx_d;
    logic                 accept, in_last_beat, pop;
    logic [FIFO_W-1:0]    head;

    // Config FSM, input gating and input framing. A pending reconfiguration
    // only takes effect on a frame boundary, so frames are never split.
    always_comb begin
        state_d       = state_q;
        mode_l_d      = mode_l_q;
        scale_l_d     = scale_l_q;
        reconf_pend_d = reconf_pend_q;
        in_cnt_d      = in_cnt_q;

        cfg_tdata                                = '0;
        cfg_tdata[CFG_MODE_BIT]                  = mode_l_q;
        cfg_tdata[CFG_SCALE_LSB +: SCALE_W]      = scale_l_q;
        cfg_tvalid = (state_q == CFG_SEND) && !rst;
        cfg_busy   = cfg_tvalid;

        data_in_ready = !rst && (state_q == RUN) && core_s_tready &&
                        !(reconf_pend_q && (in_cnt_q == '0));
        accept        = data_in_en && data_in_ready;
        in_last_beat  = (in_cnt_q == CNT_LAST);
        core_s_tvalid = accept;
        core_s_tdata  = {data_in_im, data_in_re};
        core_s_tlast  = accept && in_last_beat;
        in_err        = accept && (data_in_last != in_last_beat);
        if (accept) in_cnt_d = in_cnt_q + CNT_ONE;

        case (state_q)
            CFG_SEND: if (cfg_tready) state_d = RUN;
            RUN: begin
                if ({fft_mode, scale_sch} != {mode_l_q, scale_l_q}) reconf_pend_d = 1'b1;
                if (reconf_pend_q && (in_cnt_q == '0) && !accept) begin
                    mode_l_d      = fft_mode;
                    scale_l_d     = scale_sch;
                    reconf_pend_d = 1'b0;
                    state_d       = CFG_SEND;
                end
            end
            default: state_d = CFG_SEND;
        endcase
    end

    // Control state; reset captures the current settings for the first config.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q       <= CFG_SEND;
            mode_l_q      <= fft_mode;
            scale_l_q     <= scale_sch;
            reconf_pend_q <= 1'b0;
            in_cnt_q      <= '0;
            out_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            mode_l_q      <= mode_l_d;
            scale_l_q     <= scale_l_d;
            reconf_pend_q <= reconf_pend_d;
            in_cnt_q      <= in_cnt_d;
            out_idx_q     <= out_idx_d;
        end
    end

    fft_skid_fifo #(.W(FIFO_W)) u_out_fifo (
        .clk       (aclk),
        .rst       (rst),
        .in_valid  (core_m_tvalid),
        .in_ready  (core_m_tready),
        .in_data   ({core_m_tlast, core_m_tdata}),
        .out_valid (data_out_valid),
        .out_ready (data_out_ready),
        .out_data  (head)
    );

    // Output unpacking, bin index and output framing check.
    always_comb begin
        {data_out_last, data_out_im, data_out_re} = head;
        pop          = data_out_valid && data_out_ready;
        out_idx_d    = pop ? out_idx_q + CNT_ONE : out_idx_q;
        out_err      = pop && (data_out_last != (out_idx_q == CNT_LAST));
        data_out_idx = out_idx_q;
    end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Scoreboard bench for fft_stream_ctrl with NFFT = 16.
module tb_fft_stream_ctrl;
    localparam int DW = 32;
    localparam int NL = 4;
    localparam int SW = 8;
    localparam int CW = 16;

    logic            aclk = 1'b0;
    logic            rst;
    logic [DW-1:0]   data_in_re, data_in_im;
    logic            data_in_en, data_in_last, data_in_ready;
    logic            fft_mode;
    logic [SW-1:0]   scale_sch;
    logic            cfg_tvalid, cfg_tready;
    logic [CW-1:0]   cfg_tdata;
    logic            core_s_tvalid, core_s_tready, core_s_tlast;
    logic [2*DW-1:0] core_s_tdata;
    logic            core_m_tvalid, core_m_tready, core_m_tlast;
    logic [2*DW-1:0] core_m_tdata;
    logic [DW-1:0]   data_out_re, data_out_im;
    logic            data_out_valid, data_out_ready, data_out_last;
    logic [NL-1:0]   data_out_idx;
    logic            in_err, out_err, cfg_busy;

    always #5 aclk = ~aclk;

    fft_stream_ctrl #(.DATA_W(DW), .NFFT_LOG2(NL), .SCALE_W(SW), .CFG_W(CW)) dut (
        .aclk(aclk), .rst(rst),
        .data_in_re(data_in_re), .data_in_im(data_in_im), .data_in_en(data_in_en),
        .data_in_last(data_in_last), .data_in_ready(data_in_ready),
        .fft_mode(fft_mode), .scale_sch(scale_sch),
        .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
        .core_s_tvalid(core_s_tvalid), .core_s_tready(core_s_tready),
        .core_s_tdata(core_s_tdata), .core_s_tlast(core_s_tlast),
        .core_m_tvalid(core_m_tvalid), .core_m_tready(core_m_tready),
        .core_m_tdata(core_m_tdata), .core_m_tlast(core_m_tlast),
        .data_out_re(data_out_re), .data_out_im(data_out_im),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_last(data_out_last), .data_out_idx(data_out_idx),
        .in_err(in_err), .out_err(out_err), .cfg_busy(cfg_busy)
    );

    typedef struct { logic [63:0] d; logic last; logic err; } in_exp_t;
    typedef struct { logic [63:0] d; logic last; logic [NL-1:0] idx; } out_exp_t;

    in_exp_t    exp_in[$];
    out_exp_t   exp_out[$];
    logic [15:0] exp_cfg[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Input-side monitor: every accepted beat must match the next expectation.
    always @(negedge aclk) begin
        in_exp_t e;
        if (core_s_tvalid) begin
            if (exp_in.size() == 0) flag("in_unexpected_beat");
            else begin
                e = exp_in.pop_front();
                chk("in_data", core_s_tdata, e.d);
                chk("in_tlast", {63'd0, core_s_tlast}, {63'd0, e.last});
                chk("in_err", {63'd0, in_err}, {63'd0, e.err});
            end
        end else if (in_err) flag("in_err_without_beat");
    end

    // Config monitor.
    always @(negedge aclk) begin
        logic [15:0] c;
        if (cfg_tvalid && cfg_tready) begin
            if (exp_cfg.size() == 0) flag("cfg_unexpected");
            else begin
                c = exp_cfg.pop_front();
                chk("cfg_tdata", {48'd0, cfg_tdata}, {48'd0, c});
            end
        end
    end

    // Output monitor.
    always @(negedge aclk) begin
        out_exp_t o;
        if (data_out_valid && data_out_ready) begin
            if (exp_out.size() == 0) flag("out_unexpected");
            else begin
                o = exp_out.pop_front();
                chk("out_data", {data_out_im, data_out_re}, o.d);
                chk("out_last", {63'd0, data_out_last}, {63'd0, o.last});
                chk("out_idx", {60'd0, data_out_idx}, {60'd0, o.idx});
                chk("out_err", {63'd0, out_err}, 64'd0);
            end
        end else if (out_err) flag("out_err_without_pop");
    end

    // Present one input beat (caller sits at posedge+1) and wait for acceptance.
    task automatic in_beat(input int base, input int i, input logic lst);
        in_exp_t e;
        int n = 0;
        data_in_re   = 32'(base + i);
        data_in_im   = 32'(base + i + 32'h8000);
        data_in_last = lst;
        data_in_en   = 1'b1;
        e.d    = {data_in_im, data_in_re};
        e.last = (i == 15);
        e.err  = (lst != (i == 15));
        exp_in.push_back(e);
        @(negedge aclk);
        while (!data_in_ready && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) flag("in_accept_timeout");
        @(posedge aclk); #1;
    endtask

    task automatic in_frame(input int base, input int mark);
        for (int i = 0; i < 16; i++) in_beat(base, i, i == mark);
        data_in_en   = 1'b0;
        data_in_last = 1'b0;
    endtask

    // Present one core output beat; optionally register it as expected output.
    task automatic core_beat(input int base, input int i, input logic lst, input logic track, input int idx);
        out_exp_t o;
        int n = 0;
        core_m_tvalid = 1'b1;
        core_m_tdata  = {32'(base + i + 32'h4000), 32'(base + i)};
        core_m_tlast  = lst;
        if (track) begin
            o.d = core_m_tdata; o.last = lst; o.idx = NL'(idx);
            exp_out.push_back(o);
        end
        @(negedge aclk);
        while (!core_m_tready && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) flag("core_accept_timeout");
        @(posedge aclk); #1;
    endtask

    // Wait for the config handshake; input must open the following cycle.
    task automatic wait_cfg(input string name);
        int n = 0;
        @(negedge aclk);
        while (!(cfg_tvalid && cfg_tready) && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) flag({name, "_cfg_timeout"});
        @(negedge aclk);
        chk({name, "_cfg_tvalid_low"}, {63'd0, cfg_tvalid}, 64'd0);
        chk({name, "_in_ready_high"}, {63'd0, data_in_ready}, 64'd1);
    endtask

    task automatic drain_out(input string name);
        int n = 0;
        while (exp_out.size() > 0 && n < 60) begin @(negedge aclk); n++; end
        chk({name, "_out_drained"}, 64'(exp_out.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fft_mode = 1'b1; scale_sch = 8'h00; cfg_tready = 1'b0;
        core_s_tready = 1'b1; data_in_en = 1'b0; data_in_last = 1'b0;
        data_in_re = '0; data_in_im = '0;
        core_m_tvalid = 1'b0; core_m_tdata = '0; core_m_tlast = 1'b0;
        data_out_ready = 1'b1;

        // 1. reset state and initial config held under back-pressure
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_cfg_tvalid", {63'd0, cfg_tvalid}, 64'd0);
        chk("rst_cfg_busy", {63'd0, cfg_busy}, 64'd0);
        chk("rst_in_ready", {63'd0, data_in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, data_out_valid}, 64'd0);
        chk("rst_core_m_tready", {63'd0, core_m_tready}, 64'd0);
        @(posedge aclk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("init_cfg_tvalid", {63'd0, cfg_tvalid}, 64'd1);
            chk("init_cfg_busy", {63'd0, cfg_busy}, 64'd1);
            chk("init_cfg_tdata", {48'd0, cfg_tdata}, 64'h0001);
            chk("init_in_ready_low", {63'd0, data_in_ready}, 64'd0);
        end
        @(posedge aclk); #1;
        cfg_tready = 1'b1;
        exp_cfg.push_back(16'h0001);
        wait_cfg("init");
        chk("init_core_m_tready", {63'd0, core_m_tready}, 64'd1);
        @(posedge aclk); #1;

        // 2. clean frame
        in_frame(32'h100, 15);
        @(negedge aclk);
        chk("clean_in_cnt_zero", 64'(dut.in_cnt_q), 64'd0);
        @(posedge aclk); #1;

        // 3. early marker on beat 10, missing marker on beat 16
        in_frame(32'h200, 9);

        // 4. mode change on beat 5; frame completes, then reconfig
        for (int i = 0; i < 16; i++) begin
            if (i == 4) fft_mode = 1'b0;
            in_beat(32'h300, i, i == 15);
        end
        data_in_en = 1'b0; data_in_last = 1'b0;
        @(negedge aclk);
        chk("reconf_in_ready_low", {63'd0, data_in_ready}, 64'd0);
        exp_cfg.push_back(16'h0000);
        wait_cfg("reconf");
        @(posedge aclk); #1;

        // 5. output burst with a 4-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 16; i++) core_beat(32'h500, i, i == 15, 1'b1, i);
                core_m_tvalid = 1'b0; core_m_tlast = 1'b0;
            end
            begin
                repeat (5) @(posedge aclk);
                #1 data_out_ready = 1'b0;
                repeat (4) @(posedge aclk);
                #1 data_out_ready = 1'b1;
            end
        join
        drain_out("burst");
        @(posedge aclk); #1;

        // 6. reset mid-frame with output buffered and out_idx non-zero
        core_beat(32'h600, 0, 1'b0, 1'b1, 0);
        core_beat(32'h600, 1, 1'b0, 1'b1, 1);
        core_m_tvalid = 1'b0;
        repeat (2) @(posedge aclk); #1;
        chk("pre_rst_out_drained", 64'(exp_out.size()), 64'd0);
        data_out_ready = 1'b0;
        core_beat(32'h600, 2, 1'b0, 1'b0, 0);
        core_m_tvalid = 1'b0;
        for (int i = 0; i < 6; i++) in_beat(32'h700, i, 1'b0);
        rst = 1'b1; cfg_tready = 1'b0; fft_mode = 1'b1; scale_sch = 8'hA5;
        data_in_re = 32'h7006;
        @(negedge aclk);
        chk("mid_rst_in_ready", {63'd0, data_in_ready}, 64'd0);
        chk("mid_rst_cfg_tvalid", {63'd0, cfg_tvalid}, 64'd0);
        @(posedge aclk); @(posedge aclk); #1;
        rst = 1'b0; data_in_en = 1'b0;
        data_out_ready = 1'b1;
        @(negedge aclk);
        chk("post_rst_cfg_tvalid", {63'd0, cfg_tvalid}, 64'd1);
        chk("post_rst_cfg_tdata", {48'd0, cfg_tdata}, 64'h014B);
        chk("post_rst_out_valid", {63'd0, data_out_valid}, 64'd0);
        chk("post_rst_in_cnt", 64'(dut.in_cnt_q), 64'd0);
        chk("post_rst_out_idx", 64'(dut.out_idx_q), 64'd0);
        @(posedge aclk); #1;
        cfg_tready = 1'b1;
        exp_cfg.push_back(16'h014B);
        wait_cfg("post_rst");
        @(posedge aclk); #1;
        in_frame(32'h800, 15);
        core_beat(32'h900, 0, 1'b0, 1'b1, 0);
        core_m_tvalid = 1'b0;
        drain_out("post_rst");

        repeat (3) @(negedge aclk);
        chk("in_queue_empty", 64'(exp_in.size()), 64'd0);
        chk("cfg_queue_empty", 64'(exp_cfg.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
